// File: rtl/router_pkg.sv
// Shared types and constants for the router packet writer slice.
package router_pkg;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 8;
  localparam int NUM_DEST = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_t;

  // Address 3 shifts out of range and yields no strobe at all.
  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [ADDR_W-1:0] addr);
    return NUM_DEST'(1) << addr;
  endfunction

endpackage

// File: rtl/router_byte_hold.sv
// Byte storage for the packet writer: held payload byte, received parity, parity accumulator.
// Accumulator exists only when ROUTER_PARITY_CHECK_EN is defined.
module router_byte_hold
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              hold_ld,
  input  logic              rx_par_ld,
  input  logic              par_seed,
  input  logic              par_acc,
  input  logic [DATA_W-1:0] byte_in,
  input  logic [DATA_W-1:0] par_in,
  output logic [DATA_W-1:0] hold_byte,
  output logic [DATA_W-1:0] rx_parity,
  output logic [DATA_W-1:0] calc_parity
);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hold_byte <= '0;
      rx_parity <= '0;
    end else begin
      if (hold_ld)   hold_byte <= byte_in;
      if (rx_par_ld) rx_parity <= byte_in;
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] par_acc_q;

  always_ff @(posedge clock) begin
    if (!resetn)       par_acc_q <= '0;
    else if (par_seed) par_acc_q <= par_in;
    else if (par_acc)  par_acc_q <= par_acc_q ^ par_in;
  end

  assign calc_parity = par_acc_q;
`else
  logic unused_par;
  assign unused_par  = ^{par_seed, par_acc, par_in};
  assign calc_parity = '0;
`endif

endmodule

// File: rtl/router_pkt_writer.sv
// Router input FSM: decodes the header, writes header/payload/parity into one of three FIFOs.
// Optional parity checking is enabled by defining ROUTER_PARITY_CHECK_EN.
module router_pkt_writer
  import router_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                pkt_valid,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [NUM_DEST-1:0] fifo_full,
  input  logic [NUM_DEST-1:0] fifo_empty,
  output logic                busy,
  output logic [NUM_DEST-1:0] write_enb,
  output logic                lfd_state,
  output logic [DATA_W-1:0]   data_out,
  output logic                err
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] header_q;
  logic [DATA_W-1:0] hold_byte, rx_parity, calc_parity;
  logic              we, hdr_ld, hold_ld, rx_par_ld, par_seed, par_acc;

  always_ff @(posedge clock) begin
    if (!resetn) state <= DECODE_ADDRESS;
    else         state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!resetn)     addr_q <= '0;
    else if (hdr_ld) addr_q <= data_in[ADDR_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (hdr_ld) header_q <= data_in;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    we        = 1'b0;
    lfd_state = 1'b0;
    data_out  = '0;
    hdr_ld    = 1'b0;
    hold_ld   = 1'b0;
    rx_par_ld = 1'b0;
    par_seed  = 1'b0;
    par_acc   = 1'b0;
    case (state)
      DECODE_ADDRESS: begin
        busy = 1'b0;
        if (pkt_valid && data_in[ADDR_W-1:0] != ADDR_INVALID) begin
          hdr_ld   = 1'b1;
          state_nx = fifo_empty[data_in[ADDR_W-1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (fifo_empty[addr_q]) state_nx = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        we        = 1'b1;
        lfd_state = 1'b1;
        data_out  = header_q;
        par_seed  = 1'b1;
        state_nx  = LOAD_DATA;
      end
      LOAD_DATA: begin
        busy = 1'b0;
        if (!pkt_valid) begin
          rx_par_ld = 1'b1;
          state_nx  = LOAD_PARITY;
        end else if (!fifo_full[addr_q]) begin
          we       = 1'b1;
          data_out = data_in;
          par_acc  = 1'b1;
        end else begin
          hold_ld  = 1'b1;
          state_nx = FIFO_FULL_STATE;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full[addr_q]) state_nx = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        we       = 1'b1;
        data_out = hold_byte;
        par_acc  = 1'b1;
        state_nx = LOAD_DATA;
      end
      LOAD_PARITY: begin
        if (!fifo_full[addr_q]) begin
          we       = 1'b1;
          data_out = rx_parity;
          state_nx = CHECK_PARITY_ERROR;
        end
      end
      CHECK_PARITY_ERROR: state_nx = DECODE_ADDRESS;
      default:            state_nx = DECODE_ADDRESS;
    endcase
  end

  assign write_enb = dest_onehot(addr_q) & {NUM_DEST{we}};

  router_byte_hold u_byte_hold (
    .clock       (clock),
    .resetn      (resetn),
    .hold_ld     (hold_ld),
    .rx_par_ld   (rx_par_ld),
    .par_seed    (par_seed),
    .par_acc     (par_acc),
    .byte_in     (data_in),
    .par_in      (data_out),
    .hold_byte   (hold_byte),
    .rx_parity   (rx_parity),
    .calc_parity (calc_parity)
  );

`ifdef ROUTER_PARITY_CHECK_EN
  // err is sticky across packets; only the parity check cycle rewrites it.
  always_ff @(posedge clock) begin
    if (!resetn)                          err <= 1'b0;
    else if (state == CHECK_PARITY_ERROR) err <= (calc_parity != rx_parity);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/router_pkt_writer.md
ROUTER_PKT_WRITER -- requirements
Module: router_pkt_writer

Interface
REQ-001 SHALL have: clock  input  1  system clock, rising edge.
REQ-002 SHALL have: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: pkt_valid  input  1  sender asserts from header through last payload byte; low on the parity byte.
REQ-004 SHALL have: data_in  input  8  packet byte; header = {len[7:2], addr[1:0]}.
REQ-005 SHALL have: fifo_full  input  3  full flag per destination FIFO.
REQ-006 SHALL have: fifo_empty  input  3  empty flag per destination FIFO.
REQ-007 SHALL have: busy  output  1  sender must hold data_in and pkt_valid while high.
REQ-008 SHALL have: write_enb  output  3  one-hot write strobe to destination FIFO.
REQ-009 SHALL have: lfd_state  output  1  marks header write; drives the FIFO's bit 8.
REQ-010 SHALL have: data_out  output  8  byte to FIFO data_in.
REQ-011 SHALL have: err  output  1  parity mismatch flag for last packet.

Function
REQ-012 SHALL implement states DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR.
REQ-013 SHALL assert busy in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-014 DECODE_ADDRESS: pkt_valid with addr<3 latches header and addr; -> LOAD_FIRST_DATA if fifo_empty[addr], else -> WAIT_TILL_EMPTY.
REQ-015 DECODE_ADDRESS: pkt_valid with addr==3 -> drop the packet, stay, no write, no busy.
REQ-016 WAIT_TILL_EMPTY: hold until fifo_empty[addr]=1, then -> LOAD_FIRST_DATA.
REQ-017 LOAD_FIRST_DATA: one cycle with write_enb[addr]=1, lfd_state=1, data_out=header, parity seeded with header; -> LOAD_DATA.
REQ-018 LOAD_DATA, pkt_valid=1, fifo_full[addr]=0: write data_in and XOR it into parity in the same cycle.
REQ-019 LOAD_DATA, pkt_valid=1, fifo_full[addr]=1: no write; capture byte in hold register; -> FIFO_FULL_STATE.
REQ-020 LOAD_DATA, pkt_valid=0: capture data_in as received parity; -> LOAD_PARITY.
REQ-021 FIFO_FULL_STATE: stay while fifo_full[addr]; else -> LOAD_AFTER_FULL.
REQ-022 LOAD_AFTER_FULL: write the held byte, XOR it into parity; -> LOAD_DATA.
REQ-023 LOAD_PARITY: write the received parity byte when fifo_full[addr]=0 and go to CHECK_PARITY_ERROR; otherwise stay.
REQ-024 CHECK_PARITY_ERROR: one cycle; err <= (computed != received parity); -> DECODE_ADDRESS.
REQ-025 err SHALL hold until the next CHECK_PARITY_ERROR; a new packet does not clear it.
REQ-026 write_enb SHALL be zero or one-hot; it SHALL never assert for an address other than the latched addr.
REQ-027 The len field SHALL NOT be checked; packet end is defined only by pkt_valid falling.

Reset
REQ-028 While resetn=0 at clock edge: state=DECODE_ADDRESS, busy=0, write_enb=0, lfd_state=0, data_out=0, err=0, parity and hold register 0.
REQ-029 Reset mid-packet SHALL abandon the packet; no further writes occur.

Configuration
REQ-030 ROUTER_PARITY_CHECK_EN defined: parity computed and err behaves per REQ-024.
REQ-031 ROUTER_PARITY_CHECK_EN undefined: no parity XOR logic; err tied 0; the parity byte is still written and CHECK_PARITY_ERROR still lasts one cycle, so timing is identical.

Structure
REQ-032 Package router_pkg SHALL hold the state enum, ADDR_W=2, DATA_W=8, NUM_DEST=3 and ADDR_INVALID=2'b11.
REQ-033 Sub-module router_byte_hold SHALL contain the hold register, received-parity register and parity accumulator; the FSM stays in router_pkt_writer.

Verification
REQ-034 Header 8'h0D (len 3, addr 1), payload 11,22,33, parity = XOR of all bytes, FIFOs empty -> write_enb=3'b010 for 5 cycles, lfd_state only on the header, err=0.
REQ-035 Same packet with parity byte 8'h00 -> err=1 after CHECK_PARITY_ERROR; err stays 1 through the next idle.
REQ-036 Header addr 0 with fifo_empty[0]=0 -> busy=1 and no write until fifo_empty[0] rises, then the header is written the next cycle.
REQ-037 fifo_full[2] asserted at payload byte 2 for 4 cycles -> busy=1, byte held, then written once in LOAD_AFTER_FULL; no byte lost or duplicated.
REQ-038 Header 8'h07 (addr 3) -> write_enb stays 0, busy stays 0, FSM remains in DECODE_ADDRESS.
REQ-039 resetn=0 during LOAD_DATA -> next cycle all outputs 0 and state DECODE_ADDRESS; a fresh packet then completes normally.
